// File: rtl/psr_cond_unit.sv
// ---------------------------------------------------------------------------
// psr_cond_unit
//
// Processor status register (PSR) placed between the ALU flags output and the
// fetch/branch control FSM. The block:
//   - holds the five ALU flags {Z,C,F,N,L} and updates them under a per-bit
//     write mask,
//   - evaluates one of 16 branch condition codes per cycle against the held
//     flags and returns a registered take/not-take decision with a one-cycle
//     valid pulse,
//   - keeps a small LIFO of saved PSR values for interrupt/call context, with
//     a sticky error flag for overflow and underflow.
//
// Optional build macro:
//   PSR_FLAG_BYPASS_EN - when defined, a condition evaluated in the same cycle
//                        as a flag write sees the merged next-state PSR (or
//                        the popped value when a pop also happens). When it is
//                        undefined, evaluation always uses the registered PSR.
//
// Parameters:
//   STACK_DEPTH - number of PSR save slots (power of two, 2..16)
//   PTR_W       - log2(STACK_DEPTH)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   flags_in     in   [4:0] ALU flags: 4 Zero, 3 Carry, 2 Overflow, 1 Negative,
//                     0 Low
//   flag_we      in   update PSR from flags_in this cycle
//   flag_mask    in   [4:0] per-bit update enable
//   cond         in   [3:0] condition code to evaluate
//   cond_valid   in   evaluate cond this cycle
//   take         out  registered result of the last evaluation
//   take_valid   out  one-cycle pulse qualifying take
//   psr          out  [4:0] current PSR contents
//   push         in   save psr to the stack
//   pop          in   restore psr from the stack
//   depth        out  [PTR_W:0] number of occupied slots
//   stack_full   out  depth == STACK_DEPTH
//   stack_empty  out  depth == 0
//   err          out  sticky overflow/underflow error
//   err_clr      in   synchronous clear of err
// ---------------------------------------------------------------------------
module psr_cond_unit #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned PTR_W       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       flags_in,
  input  logic             flag_we,
  input  logic [4:0]       flag_mask,
  input  logic [3:0]       cond,
  input  logic             cond_valid,
  output logic             take,
  output logic             take_valid,
  output logic [4:0]       psr,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W:0]   depth,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             err,
  input  logic             err_clr
);

  // Flag bit positions inside the PSR.
  localparam int unsigned FlagZ = 4;
  localparam int unsigned FlagC = 3;
  localparam int unsigned FlagF = 2;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagL = 0;

  localparam logic [PTR_W:0] DepthMax  = (PTR_W + 1)'(STACK_DEPTH);
  localparam logic [PTR_W:0] DepthZero = '0;
  localparam logic [PTR_W:0] DepthOne  = (PTR_W + 1)'(1);

  typedef enum logic [3:0] {
    CondEq = 4'b0000,
    CondNe = 4'b0001,
    CondCs = 4'b0010,
    CondCc = 4'b0011,
    CondHi = 4'b0100,
    CondLs = 4'b0101,
    CondGt = 4'b0110,
    CondLe = 4'b0111,
    CondFs = 4'b1000,
    CondFc = 4'b1001,
    CondLo = 4'b1010,
    CondHs = 4'b1011,
    CondLt = 4'b1100,
    CondGe = 4'b1101,
    CondUc = 4'b1110,
    CondNv = 4'b1111
  } cond_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [4:0]     psr_q, psr_d;
  logic           take_q, take_d;
  logic           take_valid_q, take_valid_d;
  logic [PTR_W:0] depth_q, depth_d;
  logic           err_q, err_d;

  // Save slots carry no reset: their contents are meaningless while depth is 0.
  logic [4:0]     stack_q [STACK_DEPTH];

  // -------------------------------------------------------------------------
  // Stack control
  // -------------------------------------------------------------------------
  logic             full, empty;
  logic             push_only, pop_only;
  logic             push_ok, pop_ok;
  logic             push_err, pop_err;
  logic [PTR_W-1:0] push_idx, pop_idx;

  assign full  = (depth_q == DepthMax);
  assign empty = (depth_q == DepthZero);

  // push and pop together cancel each other and never flag an error.
  assign push_only = push & ~pop;
  assign pop_only  = pop & ~push;

  assign push_ok  = push_only & ~full;
  assign pop_ok   = pop_only & ~empty;
  assign push_err = push_only & full;
  assign pop_err  = pop_only & empty;

  // push_idx is only used when not full, so dropping the top bit is safe.
  assign push_idx = PTR_W'(depth_q);
  assign pop_idx  = PTR_W'(depth_q - DepthOne);

  always_comb begin
    depth_d = depth_q;
    if (push_ok) begin
      depth_d = depth_q + DepthOne;
    end else if (pop_ok) begin
      depth_d = depth_q - DepthOne;
    end
  end

  // A new error in the same cycle as err_clr wins, so nothing is lost.
  always_comb begin
    err_d = err_q;
    if (push_err || pop_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // PSR next state
  // -------------------------------------------------------------------------
  logic [4:0] psr_merged;

  assign psr_merged = (flags_in & flag_mask) | (psr_q & ~flag_mask);

  // A lone pop owns the PSR for the cycle: it either restores a saved value or,
  // on underflow, leaves the PSR untouched. In both cases a concurrent flag
  // write is dropped. With push (alone or with pop) the flag write still lands;
  // the push itself saves the pre-write PSR.
  always_comb begin
    psr_d = psr_q;
    if (pop_only) begin
      if (pop_ok) begin
        psr_d = stack_q[pop_idx];
      end
    end else if (flag_we) begin
      psr_d = psr_merged;
    end
  end

  // -------------------------------------------------------------------------
  // Condition evaluation
  // -------------------------------------------------------------------------
  function automatic logic cond_eval(input logic [3:0] code, input logic [4:0] f);
    logic result;
    result = 1'b0;
    unique case (cond_e'(code))
      CondEq: result = f[FlagZ];
      CondNe: result = ~f[FlagZ];
      CondCs: result = f[FlagC];
      CondCc: result = ~f[FlagC];
      CondHi: result = f[FlagL];
      CondLs: result = ~f[FlagL];
      CondGt: result = f[FlagN];
      CondLe: result = ~f[FlagN];
      CondFs: result = f[FlagF];
      CondFc: result = ~f[FlagF];
      CondLo: result = ~f[FlagZ] & ~f[FlagL];
      CondHs: result = f[FlagZ] | f[FlagL];
      CondLt: result = ~f[FlagZ] & ~f[FlagN];
      CondGe: result = f[FlagZ] | f[FlagN];
      CondUc: result = 1'b1;
      CondNv: result = 1'b0;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

  logic [4:0] eval_flags;

`ifdef PSR_FLAG_BYPASS_EN
  // Forward the same-cycle write; psr_d already reflects a winning pop.
  assign eval_flags = flag_we ? psr_d : psr_q;
`else
  assign eval_flags = psr_q;
`endif

  always_comb begin
    take_d       = take_q;
    take_valid_d = cond_valid;
    if (cond_valid) begin
      take_d = cond_eval(cond, eval_flags);
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psr_q        <= '0;
      take_q       <= 1'b0;
      take_valid_q <= 1'b0;
      depth_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      psr_q        <= psr_d;
      take_q       <= take_d;
      take_valid_q <= take_valid_d;
      depth_q      <= depth_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_q[push_idx] <= psr_q;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign psr         = psr_q;
  assign take        = take_q;
  assign take_valid  = take_valid_q;
  assign depth       = depth_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign err         = err_q;

endmodule

// File: tb/tb_psr_cond_unit.sv
module tb_psr_cond_unit;

  logic       clk;
  logic       reset_n;
  logic [4:0] flags_in;
  logic       flag_we;
  logic [4:0] flag_mask;
  logic [3:0] cond;
  logic       cond_valid;
  logic       take;
  logic       take_valid;
  logic [4:0] psr;
  logic       push;
  logic       pop;
  logic [2:0] depth;
  logic       stack_full;
  logic       stack_empty;
  logic       err;
  logic       err_clr;

  int checks;
  int fails;

  psr_cond_unit #(
    .STACK_DEPTH(4),
    .PTR_W      (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flags_in   (flags_in),
    .flag_we    (flag_we),
    .flag_mask  (flag_mask),
    .cond       (cond),
    .cond_valid (cond_valid),
    .take       (take),
    .take_valid (take_valid),
    .psr        (psr),
    .push       (push),
    .pop        (pop),
    .depth      (depth),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .err        (err),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flags_in   = '0;
    flag_we    = 1'b0;
    flag_mask  = '0;
    cond       = '0;
    cond_valid = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    err_clr    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #2;
    checks++;
    if ({psr, depth, stack_empty, stack_full, err, take, take_valid} !== {5'b0, 3'd0, 5'b10000})
    begin
      $display("FAIL reset_state: got psr=%b depth=%0d empty=%b full=%b err=%b take=%b tv=%b",
               psr, depth, stack_empty, stack_full, err, take, take_valid);
      fails++;
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_masked_write();
    logic [3:0] codes [3];
    logic       exp_take [3];
    codes = '{4'b0000, 4'b1100, 4'b1101};
    exp_take = '{1'b1, 1'b0, 1'b1};
    flags_in = 5'b11111; flag_mask = 5'b10010; flag_we = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (psr !== 5'b10010) begin
      $display("FAIL masked_write: psr=%b expected 10010", psr); fails++;
    end
    for (int i = 0; i < 3; i++) begin
      cond = codes[i]; cond_valid = 1'b1;
      tick();
      checks++;
      if ({take_valid, take} !== {1'b1, exp_take[i]}) begin
        $display("FAIL masked_cond%0d: tv/take=%b%b expected 1%b", i, take_valid, take,
                 exp_take[i]);
        fails++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_cond_sweep();
    logic [15:0] exp_vec;
    exp_vec = 16'b0101_0110_1010_0110; // bit i = expected take for cond i
    flags_in = 5'b01000; flag_mask = 5'b11111; flag_we = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (psr !== 5'b01000) begin
      $display("FAIL sweep_psr: psr=%b expected 01000", psr); fails++;
    end
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i); cond_valid = 1'b1;
      tick();
      checks++;
      if ({take_valid, take} !== {1'b1, exp_vec[i]}) begin
        $display("FAIL sweep_cond%0d: tv/take=%b%b expected 1%b", i, take_valid, take,
                 exp_vec[i]);
        fails++;
      end
    end
    idle_inputs();
    tick();
    checks++;
    if ({take_valid, take} !== 2'b00) begin
      $display("FAIL sweep_hold: tv/take=%b%b expected 00", take_valid, take); fails++;
    end
  endtask

  task automatic test_hazard();
    logic exp_take;
`ifdef PSR_FLAG_BYPASS_EN
    exp_take = 1'b1;
`else
    exp_take = 1'b0;
`endif
    flags_in = 5'b00000; flag_mask = 5'b11111; flag_we = 1'b1;
    tick();
    flags_in = 5'b10000; flag_mask = 5'b11111; flag_we = 1'b1;
    cond = 4'b0000; cond_valid = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if ({take_valid, take} !== {1'b1, exp_take}) begin
      $display("FAIL hazard_take: tv/take=%b%b expected 1%b", take_valid, take, exp_take);
      fails++;
    end
    checks++;
    if (psr !== 5'b10000) begin
      $display("FAIL hazard_psr: psr=%b expected 10000", psr); fails++;
    end
  endtask

  task automatic test_stack();
    logic [4:0] vals [4];
    vals = '{5'b00001, 5'b00010, 5'b00100, 5'b01000};
    do_reset();
    // Load the first value, then push while writing the next one each cycle.
    flags_in = vals[0]; flag_mask = 5'b11111; flag_we = 1'b1;
    tick();
    for (int i = 1; i < 4; i++) begin
      flags_in = vals[i]; push = 1'b1;
      tick();
      checks++;
      if ({depth, psr} !== {3'(i), vals[i]}) begin
        $display("FAIL push_wr%0d: depth=%0d psr=%b expected %0d %b", i, depth, psr, i, vals[i]);
        fails++;
      end
    end
    flag_we = 1'b0;
    tick();
    checks++;
    if ({depth, stack_full, err} !== {3'd4, 1'b1, 1'b0}) begin
      $display("FAIL stack_full: depth=%0d full=%b err=%b expected 4 1 0", depth, stack_full, err);
      fails++;
    end
    tick();
    push = 1'b0;
    checks++;
    if ({depth, err} !== {3'd4, 1'b1}) begin
      $display("FAIL push_overflow: depth=%0d err=%b expected 4 1", depth, err); fails++;
    end
    for (int i = 3; i >= 0; i--) begin
      pop = 1'b1;
      tick();
      checks++;
      if ({psr, depth} !== {vals[i], 3'(i)}) begin
        $display("FAIL pop%0d: psr=%b depth=%0d expected %b %0d", i, psr, depth, vals[i], i);
        fails++;
      end
    end
    checks++;
    if (stack_empty !== 1'b1) begin
      $display("FAIL pop_empty: empty=%b expected 1", stack_empty); fails++;
    end
    tick();
    pop = 1'b0;
    checks++;
    if ({psr, depth, err} !== {5'b00001, 3'd0, 1'b1}) begin
      $display("FAIL pop_underflow: psr=%b depth=%0d err=%b expected 00001 0 1", psr, depth, err);
      fails++;
    end
  endtask

  task automatic test_simultaneous();
    // Entry: psr=00001, depth=0, err=1.
    push = 1'b1;
    tick();
    push = 1'b0;
    flags_in = 5'b10101; flag_mask = 5'b11111; flag_we = 1'b1;
    tick();
    flag_we = 1'b0;
    checks++;
    if ({depth, psr} !== {3'd1, 5'b10101}) begin
      $display("FAIL sim_setup: depth=%0d psr=%b expected 1 10101", depth, psr); fails++;
    end
    push = 1'b1; pop = 1'b1;
    tick();
    push = 1'b0; pop = 1'b0;
    checks++;
    if ({depth, err, psr} !== {3'd1, 1'b1, 5'b10101}) begin
      $display("FAIL push_pop_noop: depth=%0d err=%b psr=%b expected 1 1 10101", depth, err, psr);
      fails++;
    end
    pop = 1'b1; flags_in = 5'b11111; flag_mask = 5'b11111; flag_we = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if ({psr, depth} !== {5'b00001, 3'd0}) begin
      $display("FAIL pop_vs_we: psr=%b depth=%0d expected 00001 0", psr, depth); fails++;
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      $display("FAIL err_clr: err=%b expected 0", err); fails++;
    end
    // Clear and a fresh underflow in the same cycle: the error wins.
    err_clr = 1'b1; pop = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (err !== 1'b1) begin
      $display("FAIL clr_vs_err: err=%b expected 1", err); fails++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    flags_in = 5'b10110; flag_mask = 5'b11111; flag_we = 1'b1;
    tick();
    flag_we = 1'b0; push = 1'b1;
    tick();
    tick();
    push = 1'b0;
    cond = 4'b1110; cond_valid = 1'b1;
    tick();
    cond_valid = 1'b0;
    checks++;
    if ({depth, err, take_valid, take, psr} !== {3'd2, 1'b1, 1'b1, 1'b1, 5'b10110}) begin
      $display("FAIL mid_setup: depth=%0d err=%b tv=%b take=%b psr=%b expected 2 1 1 1 10110",
               depth, err, take_valid, take, psr);
      fails++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({psr, depth, stack_empty, stack_full, err, take, take_valid} !== {5'b0, 3'd0, 5'b10000})
    begin
      $display("FAIL reset_async: psr=%b depth=%0d empty=%b full=%b err=%b take=%b tv=%b",
               psr, depth, stack_empty, stack_full, err, take, take_valid);
      fails++;
    end
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_masked_write();
    test_cond_sweep();
    test_hazard();
    test_stack();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/psr_cond_unit.md
Name: psr_cond_unit

Overview:
- Processor status register (PSR) that consumes the ALU's 5-bit Flags output and holds it for the rest of the datapath.
- Registers ALU flags under a per-flag write mask.
- Evaluates the 16 branch/jump condition codes against the held flags and returns a registered take/not-take decision.
- Provides a small save/restore stack for interrupt/call context.
- Sits between the ALU Flags output and the fetch/branch control FSM.

Parameters:
- STACK_DEPTH, 4, number of PSR save slots (power of two, 2..16).
- PTR_W, 2, log2(STACK_DEPTH); width of the stack pointer and depth output.

Ports:
- clk  in  1  system clock, rising-edge
- reset_n  in  1  asynchronous active-low reset
- flags_in  in  5  ALU flags {Z,C,F,N,L}: bit4 Zero, bit3 Carry, bit2 Overflow, bit1 Negative, bit0 Low
- flag_we  in  1  update PSR from flags_in this cycle
- flag_mask  in  5  per-bit update enable; only bits with mask=1 are written
- cond  in  4  condition code to evaluate
- cond_valid  in  1  evaluate cond this cycle
- take  out  1  registered result of last evaluation
- take_valid  out  1  one-cycle pulse qualifying take
- psr  out  5  current PSR contents
- push  in  1  save psr to stack
- pop  in  1  restore psr from stack
- depth  out  PTR_W+1  number of occupied slots
- stack_full  out  1  depth==STACK_DEPTH
- stack_empty  out  1  depth==0
- err  out  1  sticky overflow/underflow error
- err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (async, reset_n=0): psr=0, take=0, take_valid=0, depth=0, err=0, stack_empty=1, stack_full=0. Stack contents are don't-care.
- Flag update: on a clock edge with flag_we=1, psr_next[i] = flag_mask[i] ? flags_in[i] : psr[i]. Result is visible on psr the next cycle (1-cycle latency).
- Evaluation: cond_valid sampled at edge N; take and take_valid are valid after edge N. take_valid is high for exactly one cycle per cond_valid. Back-to-back cond_valid gives back-to-back results. take holds its value when take_valid=0.
- Condition codes:
  - 0000 EQ Z=1; 0001 NE Z=0
  - 0010 CS C=1; 0011 CC C=0
  - 0100 HI L=1; 0101 LS L=0
  - 0110 GT N=1; 0111 LE N=0
  - 1000 FS F=1; 1001 FC F=0
  - 1010 LO Z=0&L=0; 1011 HS Z=1|L=1
  - 1100 LT Z=0&N=0; 1101 GE Z=1|N=1
  - 1110 UC always 1; 1111 never 0
- Default hazard rule: evaluation uses the psr value before any same-cycle flag_we update (old flags).
- Stack operations:
  - push: stack[depth]=psr; depth+1.
  - pop: psr=stack[depth-1]; depth-1.
  - Both take effect on the clock edge; one op per cycle.
- Boundary rules:
  - push while full: ignored; err set.
  - pop while empty: ignored, psr unchanged; err set.
  - push&pop same cycle: no-op, err unchanged.
  - pop&flag_we same cycle: pop wins and flag_we is discarded.
  - push&flag_we same cycle: the old psr is saved and the new flags are written.
  - err_clr&new error same cycle: err ends at 1.
  - Reset mid-operation: everything returns to reset values immediately; a pending take_valid is lost.
- depth never exceeds STACK_DEPTH and never wraps.

Optional Feature:
- Macro: PSR_FLAG_BYPASS_EN.
- Defined: when flag_we and cond_valid occur in the same cycle, evaluation uses the merged value psr_next (the masked new flags). If pop is also asserted that cycle, the popped value is used.
- Undefined: evaluation always uses the registered psr (old flags), as above.

Test Plan:
- Reset check: reset_n=0 mid-run with depth=2 and err=1 -> psr=00000, depth=0, stack_empty=1, err=0, take_valid=0, all immediately without a clock edge.
- Masked write: psr=00000; flags_in=11111, mask=10010, flag_we -> psr=10010 next cycle. Then cond=0000 -> take=1; cond=1100 -> take=0; cond=1101 -> take=1.
- Full condition sweep: psr=01000 (C only), cond 0..15 back-to-back -> take = 0,1,1,0,0,1,0,1,0,1,1,0,1,0,1,0 with take_valid high 16 consecutive cycles.
- Hazard: psr=00000; same cycle flag_we with flags_in=10000, mask=11111, cond=0000 -> take=0 without PSR_FLAG_BYPASS_EN, take=1 with it.
- Stack: push psr values 00001, 00010, 00100, 01000 -> stack_full=1. A fifth push -> err=1 and depth stays 4. Four pops -> psr returns 01000, 00100, 00010, 00001 on successive cycles, then stack_empty=1. A further pop -> psr stays 00001.
- Simultaneous ops: depth=1; push&pop together -> depth=1, err unchanged. Then pop&flag_we with flags_in=11111 -> psr = saved value, not 11111. err_clr -> err=0.
